// File: rtl/rect_fill_engine.sv
// Rectangle fill pixel generator: takes one clipped rectangle command and streams
// one (x, y, colour, plot) write per clock in row-major order to the VGA adapter.
module rect_fill_engine #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int CW       = 3
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    input  logic [CW-1:0] colour_in,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [CW-1:0] r_colour;
    logic          r_plot;
    logic          r_busy;
    logic          r_done;
    logic [XW-1:0] r_x0;
    logic [XW-1:0] r_xe;
    logic [YW-1:0] r_ye;

    // End coordinates use one extra bit so x0+w-1 cannot wrap before clipping.
    logic [XW:0]   w_xe_full;
    logic [YW:0]   w_ye_full;
    logic [XW-1:0] w_xe;
    logic [YW-1:0] w_ye;
    logic          w_empty;

    always_comb begin
        w_xe_full = {1'b0, x0} + {1'b0, w} - (XW+1)'(1);
        w_ye_full = {1'b0, y0} + {1'b0, h} - (YW+1)'(1);
        w_xe      = (w_xe_full > (XW+1)'(SCREEN_W - 1)) ? XW'(SCREEN_W - 1) : w_xe_full[XW-1:0];
        w_ye      = (w_ye_full > (YW+1)'(SCREEN_H - 1)) ? YW'(SCREEN_H - 1) : w_ye_full[YW-1:0];
        w_empty   = (w == '0) || (h == '0) ||
                    ({1'b0, x0} >= (XW+1)'(SCREEN_W)) ||
                    ({1'b0, y0} >= (YW+1)'(SCREEN_H));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_x0     <= '0;
            r_xe     <= '0;
            r_ye     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (w_empty) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_x0     <= x0;
                            r_xe     <= w_xe;
                            r_ye     <= w_ye;
                            r_x      <= x0;
                            r_y      <= y0;
                            r_colour <= colour_in;
                            r_plot   <= 1'b1;
                            r_state  <= DRAW;
                        end
                    end
                end
                DRAW: begin
                    if (r_x < r_xe) begin
                        r_x <= r_x + XW'(1);
                    end else if (r_y < r_ye) begin
                        r_x <= r_x0;
                        r_y <= r_y + YW'(1);
                    end else begin
                        r_plot  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_plot  <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: each rectangle command is checked for pixel
// order, clipping, plot count, busy length and a single done pulse.
module tb_rect_fill_engine;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] w;
    logic [6:0] h;
    logic [2:0] colour_in;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    rect_fill_engine dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .w         (w),
        .h         (h),
        .colour_in (colour_in),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issues one command and follows it to IDLE. Expected clipped bounds are given by the caller.
    // When inj_at >= 0, a second start with altered inputs is pulsed at that plot index.
    task automatic run_cmd(input string tag,
                           input int cx0, input int cy0, input int cw, input int ch, input int ccol,
                           input int exs, input int eys, input int exe, input int eye,
                           input int exp_count, input int inj_at);
        int ex, ey, cnt, bad, busy_cnt, done_cnt, first_x, first_y, last_x, last_y;
        bit injected;
        ex = exs; ey = eys; cnt = 0; bad = 0; busy_cnt = 0; done_cnt = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1; injected = 0;
        x0 = cx0[7:0]; y0 = cy0[6:0]; w = cw[7:0]; h = ch[6:0]; colour_in = ccol[2:0];
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 19400; i++) begin
            if (injected) start = 1'b0;
            if (busy) busy_cnt++;
            if (plot) begin
                if (cnt == 0) begin first_x = int'(x); first_y = int'(y); end
                last_x = int'(x); last_y = int'(y);
                if (int'(x) != ex || int'(y) != ey || int'(colour) != ccol) bad++;
                if (ex < exe) ex++;
                else begin ex = exs; ey++; end
                if (cnt == inj_at && !injected) begin
                    x0 = 8'd77; y0 = 7'd33; w = 8'd2; h = 7'd2; colour_in = ~ccol[2:0];
                    start = 1'b1;
                    injected = 1;
                end
                cnt++;
            end
            if (done) begin
                done_cnt++;
                check({tag, "_done_plot_low"}, int'(plot), 0);
                break;
            end
            step();
        end
        start = 1'b0;
        step();
        check({tag, "_plot_count"}, cnt, exp_count);
        check({tag, "_pixel_errors"}, bad, 0);
        check({tag, "_done_seen"}, done_cnt, 1);
        check({tag, "_busy_cycles"}, busy_cnt, exp_count + 1);
        check({tag, "_done_cleared"}, int'(done), 0);
        check({tag, "_busy_cleared"}, int'(busy), 0);
        if (exp_count > 0) begin
            check({tag, "_first_x"}, first_x, exs);
            check({tag, "_first_y"}, first_y, eys);
            check({tag, "_last_x"}, last_x, exe);
            check({tag, "_last_y"}, last_y, eye);
        end
        // Nothing must follow, in particular no queued second command.
        step();
        step();
        check({tag, "_idle_plot"}, int'(plot), 0);
        check({tag, "_idle_busy"}, int'(busy), 0);
        $display("cmd %s: x0=%0d y0=%0d w=%0d h=%0d plots=%0d busy=%0d done=%0d",
                 tag, cx0, cy0, cw, ch, cnt, busy_cnt, done_cnt);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0;
        x0 = '0; y0 = '0; w = '0; h = '0; colour_in = '0;
        #23;
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_colour", int'(colour), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        resetn = 1'b1;
        step();

        // 2x2 block; also verify first-pixel latency directly.
        x0 = 8'd10; y0 = 7'd20; w = 8'd2; h = 7'd2; colour_in = 3'b100;
        start = 1'b1;
        step();
        start = 1'b0;
        check("lat_plot", int'(plot), 1);
        check("lat_x", int'(x), 10);
        check("lat_y", int'(y), 20);
        check("lat_colour", int'(colour), 4);
        step(); check("p2_x", int'(x), 11); check("p2_y", int'(y), 20);
        step(); check("p3_x", int'(x), 10); check("p3_y", int'(y), 21);
        step(); check("p4_x", int'(x), 11); check("p4_y", int'(y), 21);
        check("p4_plot", int'(plot), 1);
        step(); check("2x2_done", int'(done), 1); check("2x2_plot_off", int'(plot), 0);
        check("2x2_busy_in_done", int'(busy), 1);
        step(); check("2x2_done_off", int'(done), 0); check("2x2_busy_off", int'(busy), 0);
        check("2x2_x_hold", int'(x), 11);
        check("2x2_colour_hold", int'(colour), 4);

        run_cmd("sq2x2", 10, 20, 2, 2, 4, 10, 20, 11, 21, 4, -1);
        run_cmd("clip", 158, 119, 5, 3, 2, 158, 119, 159, 119, 2, -1);
        run_cmd("w0", 5, 5, 0, 5, 1, 0, 0, 0, 0, 0, -1);
        run_cmd("h0", 5, 5, 3, 0, 1, 0, 0, 0, 0, 0, -1);
        run_cmd("offscr_x", 160, 5, 3, 3, 1, 0, 0, 0, 0, 0, -1);
        run_cmd("offscr_y", 5, 120, 3, 3, 1, 0, 0, 0, 0, 0, -1);
        run_cmd("busy_start", 0, 0, 4, 4, 5, 0, 0, 3, 3, 16, 6);
        run_cmd("row1", 100, 7, 30, 1, 6, 100, 7, 129, 7, 30, -1);

        // Reset mid-draw of a 10x10 at the 3rd plot.
        x0 = 8'd50; y0 = 7'd50; w = 8'd10; h = 7'd10; colour_in = 3'b011;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("rd_3rd_x", int'(x), 52);
        check("rd_3rd_plot", int'(plot), 1);
        #2;
        resetn = 1'b0;
        #1;
        check("rd_plot", int'(plot), 0);
        check("rd_busy", int'(busy), 0);
        check("rd_done", int'(done), 0);
        check("rd_x", int'(x), 0);
        #2;
        resetn = 1'b1;
        step();
        check("rd_after_plot", int'(plot), 0);
        check("rd_after_done", int'(done), 0);
        run_cmd("after_rst", 0, 0, 1, 1, 7, 0, 0, 0, 0, 1, -1);

        run_cmd("full", 0, 0, 160, 120, 1, 0, 0, 159, 119, 19200, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
